// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared control struct, ALU op codes, and XLEN for the ID/EX/FWD stages
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic [3:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Same-cycle register-file write is not yet visible in the decode read data.
  function automatic logic [XLEN-1:0] wb_bypass(
    input logic            wb_regwrite,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data,
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data
  );
    if (wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == rs))
      return wb_data;
    return rf_data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect : combinational load-use detection and IF/ID stall request
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_detect
  import riscv_pkg::*;
(
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_flush,
  input  logic       mem_hold,
  output logic       load_use,
  output logic       stall_if_id
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  assign load_use = ex_valid && ex_memread && (ex_rd != REG_ZERO)
                  && (rs1_hit || rs2_hit) && id_valid;

  // rst_n gating keeps a held-high mem_hold from stalling fetch during reset.
  assign stall_if_id = rst_n && (load_use || mem_hold) && !ex_flush;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use bubble, flush, hold and WB bypass
// Optional bubble counter enabled by macro ID_EX_BUBBLE_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  ctrl_t           id_ctrl,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  input  logic            mem_hold,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output ctrl_t           ex_ctrl,
  output logic            stall_if_id,
  output logic [31:0]     bubble_cnt
);

  logic load_use;

  hazard_detect u_hazard_detect (
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_ctrl.memread),
    .ex_rd       (ex_rd),
    .ex_flush    (ex_flush),
    .mem_hold    (mem_hold),
    .load_use    (load_use),
    .stall_if_id (stall_if_id)
  );

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign rs1_fwd = wb_bypass(wb_regwrite, wb_rd, wb_data, id_rs1, id_rs1_data);
  assign rs2_fwd = wb_bypass(wb_regwrite, wb_rd, wb_data, id_rs2, id_rs2_data);

  // Flush beats hold; an invalid decode slot is loaded as a clean bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || ex_flush || (!mem_hold && (load_use || !id_valid))) begin
      if (!rst_n || ex_flush || !mem_hold) begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_imm      <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_rs1      <= REG_ZERO;
        ex_rs2      <= REG_ZERO;
        ex_rd       <= REG_ZERO;
        ex_ctrl     <= CTRL_NOP;
      end
    end else if (!mem_hold) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_rs1_data <= rs1_fwd;
      ex_rs2_data <= rs2_fwd;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_ctrl;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_q;
  logic        bubble_evt;

  assign bubble_evt = ex_flush || (!mem_hold && load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_q <= '0;
    else if (bubble_evt && (bubble_q != 32'hFFFF_FFFF))
      bubble_q <= bubble_q + 32'd1;
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 id_valid  input  1  decode stage holds a valid instruction.
REQ-004 id_pc, id_imm, id_rs1_data, id_rs2_data  input  32 each  decoded PC, immediate, register-file read data.
REQ-005 id_rs1, id_rs2, id_rd  input  5 each  source/destination register indices.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-007 id_ctrl  input  ctrl_t  regwrite, memread, memwrite, memtoreg, alusrc, branch, aluop[3:0].
REQ-008 wb_regwrite, wb_rd, wb_data  input  1/5/32  write-back port, same-cycle register-file write.
REQ-009 ex_flush  input  1  taken branch/jump resolved in EX; kill the instruction in decode.
REQ-010 mem_hold  input  1  downstream memory wait; freeze this register.
REQ-011 ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_ctrl  output  registered EX-stage copy; ex_rs1/ex_rs2/ex_rd feed the forwarding unit.
REQ-012 stall_if_id  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-013 bubble_cnt  output  32  bubbles inserted (see Configuration).

Function
REQ-014 load_use = ex_valid & ex_ctrl.memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & id_valid.
REQ-015 stall_if_id = (load_use | mem_hold) & ~ex_flush.
REQ-016 Per-edge priority: ex_flush > mem_hold > load_use > capture.
REQ-017 ex_flush: load bubble (ex_valid=0, ex_ctrl all zero, data/indices zero) regardless of mem_hold/load_use.
REQ-018 mem_hold (no flush): all outputs retain current values.
REQ-019 load_use (no flush, no hold): load bubble; decode instruction is re-presented next cycle by upstream stall.
REQ-020 capture: all ex_* take id_* values; ex_valid=id_valid; id_valid=0 loads a bubble.
REQ-021 Write-back bypass at capture: if wb_regwrite & wb_rd!=0 & wb_rd==id_rs1, ex_rs1_data=wb_data; same independently for rs2.
REQ-022 Bubble: ctrl.regwrite=0, memwrite=0, so no architectural effect downstream.
REQ-023 Latency: one cycle ID->EX; maximum consecutive load-use bubbles per instruction = 1.
REQ-024 x0: rd or rs index 0 never triggers load_use or bypass.

Reset
REQ-025 rst_n low asynchronously forces bubble state: ex_valid=0, all ex_* zero, bubble_cnt=0.
REQ-026 stall_if_id is 0 while in reset (ex_valid=0 removes load_use; mem_hold ignored by gating with rst_n).
REQ-027 Deassertion mid-program: first edge after release performs normal capture.

Configuration
REQ-028 Macro ID_EX_BUBBLE_CNT_EN: when defined, bubble_cnt increments by 1 on each edge loading a bubble due to load_use or ex_flush, saturating at 32'hFFFF_FFFF; not incremented during mem_hold.
REQ-029 Without ID_EX_BUBBLE_CNT_EN: port bubble_cnt exists and is constant zero; no counter flops.

Structure
REQ-030 Package riscv_pkg holds ctrl_t struct, aluop encoding constants, XLEN=32, REG_ZERO=5'd0; shared with forwarding and EX stages.
REQ-031 One sub-module hazard_detect (combinational load_use and stall_if_id), instantiated once.

Verification
REQ-032 Capture: id_valid=1, id_rd=5, id_imm=32'h10, no hazards -> next cycle ex_rd=5, ex_imm=32'h10, ex_valid=1, stall_if_id=0.
REQ-033 Load-use: EX holds lw rd=7; ID add rs1=7 -> stall_if_id=1, next cycle ex_valid=0; following cycle add captured; bubble_cnt=1 with macro, 0 without.
REQ-034 x0 load: EX lw rd=0, ID rs1=0 -> no stall, capture proceeds.
REQ-035 Bypass: wb_regwrite=1, wb_rd=3, wb_data=32'hDEAD_BEEF, id_rs2=3, id_rs2_data=0 -> ex_rs2_data=32'hDEAD_BEEF.
REQ-036 Flush+hold+load_use same cycle -> bubble loaded, stall_if_id=0.
REQ-037 mem_hold 3 cycles then release -> outputs frozen 3 cycles; rst_n pulse mid-hold -> immediate ex_valid=0, bubble_cnt=0.
